// File: rtl/core_mem_bridge_pkg.sv
// Shared encodings and bus widths for the core-to-memory bridge.
// Consumed by core_mem_bridge and mem_bridge_timeout.
package core_mem_bridge_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = DATA_BUS / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA_REQ = 2'd1,
    INST_REQ = 2'd2,
    READY    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bridge_timeout.sv
// Bus wait watchdog: counts cycles without ack, flags a sticky error.
// Only instantiated when CORE_MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge_timeout
  import core_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o,
  output logic error_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign expire_o = busy_i && !ack_i
                 && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign error_o  = err_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!busy_i || ack_i || expire_o)
      cnt_d = '0;
    err_d = err_q | expire_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/core_mem_bridge.sv
// Serialises core data access then fetch onto one req/ack bus.
// Optional bus timeout: define CORE_MEM_BRIDGE_TIMEOUT_EN.
module core_mem_bridge
  import core_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_BUS,
  parameter int DATA_WIDTH     = DATA_BUS,
  parameter int SEL_WIDTH      = MEM_SEL_BUS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [SEL_WIDTH-1:0]  rom_write_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_write_data,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  stall,
  output logic                  bus_req,
  output logic [SEL_WIDTH-1:0]  bus_write_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  output logic                  bus_error
);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [SEL_WIDTH-1:0]  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rom_q, rom_d;
  logic [DATA_WIDTH-1:0] ram_q, ram_d;
  logic                  busy, expire, done;
  logic [DATA_WIDTH-1:0] rd;
  logic                  unused_rom_wr;

  // Instruction port is read-only.
  assign unused_rom_wr = ^{rom_write_en, rom_write_data};

  assign busy = (state_q == DATA_REQ) || (state_q == INST_REQ);

`ifdef CORE_MEM_BRIDGE_TIMEOUT_EN
  mem_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (busy),
    .ack_i    (bus_ack),
    .expire_o (expire),
    .error_o  (bus_error)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_busy;
  assign unused_busy = busy;
  assign expire      = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // A timed-out transaction completes with zero read data.
  assign done = bus_ack | expire;
  assign rd   = bus_ack ? bus_read_data : '0;

  assign stall          = (state_q != READY);
  assign bus_req        = req_q;
  assign bus_write_en   = we_q;
  assign bus_addr       = addr_q;
  assign bus_write_data = wd_q;
  assign rom_read_data  = rom_q;
  assign ram_read_data  = ram_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rom_d   = rom_q;
    ram_d   = ram_q;
    unique case (state_q)
      IDLE: begin
        if (ram_en) begin
          state_d = DATA_REQ;
          req_d   = 1'b1;
          addr_d  = ram_addr;
          we_d    = ram_write_en;
          wd_d    = ram_write_data;
        end else if (rom_en) begin
          state_d = INST_REQ;
          req_d   = 1'b1;
          addr_d  = rom_addr;
          we_d    = '0;
        end else begin
          state_d = READY;
        end
      end
      DATA_REQ: begin
        if (done) begin
          if (we_q == '0)
            ram_d = rd;
          if (rom_en) begin
            state_d = INST_REQ;
            addr_d  = rom_addr;
            we_d    = '0;
          end else begin
            state_d = READY;
            req_d   = 1'b0;
          end
        end
      end
      INST_REQ: begin
        if (done) begin
          state_d = READY;
          req_d   = 1'b0;
          rom_d   = rd;
        end
      end
      READY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rom_q   <= '0;
      ram_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rom_q   <= rom_d;
      ram_q   <= ram_d;
    end
  end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge with a delayable ack bus model.
// Define CORE_MEM_BRIDGE_TIMEOUT_EN to also exercise the watchdog.
module tb_core_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_write_data;
  logic [31:0] rom_read_data;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        bus_req;
  logic [3:0]  bus_write_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_write_data;
  logic        bus_ack;
  logic [31:0] bus_read_data;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  int          delay     = 0;
  bit          never_ack = 1'b0;
  int          cnt       = 0;
  logic [31:0] rq[$];
  logic [31:0] log_addr[$];
  logic [3:0]  log_we[$];
  logic [31:0] log_wd[$];

  always #5 clk = ~clk;

  core_mem_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .SEL_WIDTH     (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_en        (rom_en),
    .rom_write_en  (rom_write_en),
    .rom_addr      (rom_addr),
    .rom_write_data(rom_write_data),
    .rom_read_data (rom_read_data),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_addr      (ram_addr),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_write_en  (bus_write_en),
    .bus_addr      (bus_addr),
    .bus_write_data(bus_write_data),
    .bus_ack       (bus_ack),
    .bus_read_data (bus_read_data),
    .bus_error     (bus_error)
  );

  // Bus slave: acks after `delay` waiting cycles, logs each transaction.
  always @(posedge clk) begin
    #1;
    bus_ack = 1'b0;
    if (rst) begin
      cnt = 0;
    end else if (bus_req && !never_ack) begin
      if (cnt == delay) begin
        bus_ack       = 1'b1;
        bus_read_data = (rq.size() > 0) ? rq.pop_front() : 32'h0;
        log_addr.push_back(bus_addr);
        log_we.push_back(bus_write_en);
        log_wd.push_back(bus_write_data);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic clear_logs();
    rq.delete();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the READY negedge.
  task automatic wait_ready(output int stalls);
    stalls = 0;
    while (stall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: stall=%b after %0d cycles, need 0", stall, stalls);
    end
  endtask

  task automatic test_reset();
    int s;
    rst = 1'b1;
    rom_en = 0; rom_write_en = 4'hF; rom_addr = 0; rom_write_data = 32'hFFFF_FFFF;
    ram_en = 0; ram_write_en = 0; ram_addr = 0; ram_write_data = 0;
    bus_ack = 0; bus_read_data = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({stall, bus_req, bus_write_en, bus_error} !== 7'b1_0_0000_0) begin
      n_fail++;
      $display("FAIL reset_ctrl: stall/req/we/err=%b need 1000000",
               {stall, bus_req, bus_write_en, bus_error});
    end
    n_checks++;
    if ({bus_addr, bus_write_data, rom_read_data, ram_read_data} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wd=%h rom=%h ram=%h need 0",
               bus_addr, bus_write_data, rom_read_data, ram_read_data);
    end
    rst = 1'b0;
    wait_ready(s);
    n_checks++;
    if (s !== 1) begin
      n_fail++;
      $display("FAIL no_request_stalls: got %0d need 1", s);
    end
  endtask

  task automatic test_fetch();
    int s;
    clear_logs();
    rq.push_back(32'h2402_0005);
    rom_en = 1; rom_addr = 32'h100; ram_en = 0;
    @(negedge clk);
    wait_ready(s);
    n_checks++;
    if (s !== 2) begin
      n_fail++;
      $display("FAIL fetch_stalls: got %0d need 2", s);
    end
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h100 || log_we[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL fetch_bus: n=%0d addr=%h we=%h need 1/100/0",
               log_addr.size(), log_addr[0], log_we[0]);
    end
    n_checks++;
    if (rom_read_data !== 32'h2402_0005) begin
      n_fail++;
      $display("FAIL fetch_data: got %h need 24020005", rom_read_data);
    end
  endtask

  task automatic test_load_fetch();
    int s;
    clear_logs();
    rq.push_back(32'hDEAD_BEEF);
    rq.push_back(32'h0);
    rom_en = 1; rom_addr = 32'h104;
    ram_en = 1; ram_write_en = 0; ram_addr = 32'h80;
    @(negedge clk);
    wait_ready(s);
    n_checks++;
    if (s !== 3) begin
      n_fail++;
      $display("FAIL load_fetch_stalls: got %0d need 3", s);
    end
    n_checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h80 || log_addr[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL load_fetch_order: n=%0d a0=%h a1=%h need 2/80/104",
               log_addr.size(), log_addr[0], log_addr[1]);
    end
    n_checks++;
    if (ram_read_data !== 32'hDEAD_BEEF || rom_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL load_fetch_data: ram=%h rom=%h need deadbeef/0",
               ram_read_data, rom_read_data);
    end
  endtask

  task automatic test_store();
    int s;
    clear_logs();
    rq.push_back(32'h5555_5555);
    rom_en = 0;
    ram_en = 1; ram_write_en = 4'b0011; ram_addr = 32'h40;
    ram_write_data = 32'h1234_ABCD;
    @(negedge clk);
    wait_ready(s);
    n_checks++;
    if (s !== 2) begin
      n_fail++;
      $display("FAIL store_stalls: got %0d need 2", s);
    end
    n_checks++;
    if (log_we[0] !== 4'b0011 || log_wd[0] !== 32'h1234_ABCD || log_addr[0] !== 32'h40) begin
      n_fail++;
      $display("FAIL store_bus: we=%b wd=%h addr=%h need 0011/1234abcd/40",
               log_we[0], log_wd[0], log_addr[0]);
    end
    n_checks++;
    if (ram_read_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_keeps_ram: got %h need deadbeef", ram_read_data);
    end
  endtask

  task automatic test_slow_bus();
    int s;
    int bad;
    clear_logs();
    rq.push_back(32'hCAFE_F00D);
    delay = 7;
    rom_en = 0;
    ram_en = 1; ram_write_en = 0; ram_addr = 32'h200;
    @(negedge clk);
    s = 1;
    bad = 0;
    @(negedge clk);
    while (stall === 1'b1 && s < 50) begin
      s++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_write_en !== 4'h0)
        bad++;
      @(negedge clk);
    end
    delay = 0;
    n_checks++;
    if (s !== 9 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_stalls: got %0d stall=%b need 9/0", s, stall);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL slow_stable: %0d unstable cycles need 0", bad);
    end
    n_checks++;
    if (ram_read_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL slow_data: got %h need cafef00d", ram_read_data);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_logs();
    delay = 5;
    rom_en = 1; rom_addr = 32'h308;
    ram_en = 1; ram_write_en = 0; ram_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL mid_pre: req=%b addr=%h need 1/300", bus_req, bus_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, stall} !== 2'b01 || rom_read_data !== 32'h0 || ram_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b stall=%b rom=%h ram=%h need 0/1/0/0",
               bus_req, stall, rom_read_data, ram_read_data);
    end
    @(negedge clk);
    delay = 0;
    clear_logs();
    rq.push_back(32'h1111_2222);
    ram_en = 0; rom_en = 1; rom_addr = 32'h400;
    rst = 1'b0;
    wait_ready(s);
    n_checks++;
    if (s !== 2 || rom_read_data !== 32'h1111_2222 || log_addr[0] !== 32'h400) begin
      n_fail++;
      $display("FAIL mid_recover: stalls=%0d rom=%h addr=%h need 2/11112222/400",
               s, rom_read_data, log_addr[0]);
    end
  endtask

`ifdef CORE_MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int s;
    clear_logs();
    never_ack = 1'b1;
    rom_en = 1; rom_addr = 32'h500; ram_en = 0;
    @(negedge clk);
    wait_ready(s);
    never_ack = 1'b0;
    n_checks++;
    if (s !== 5 || rom_read_data !== 32'h0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: stalls=%0d rom=%h req=%b need 5/0/0",
               s, rom_read_data, bus_req);
    end
    n_checks++;
    if (bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got %b need 1", bus_error);
    end
    rq.push_back(32'h0000_0077);
    rom_addr = 32'h504;
    @(negedge clk);
    wait_ready(s);
    n_checks++;
    if (s !== 2 || rom_read_data !== 32'h77 || bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: stalls=%0d rom=%h err=%b need 2/77/1",
               s, rom_read_data, bus_error);
    end
  endtask
`else
  task automatic test_no_timeout();
    n_checks++;
    if (bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_tied: got %b need 0", bus_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_slow_bus();
    test_reset_mid();
`ifdef CORE_MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
- Sits directly downstream of the CPU core's ROM and RAM ports.
- Serialises the core's instruction fetch and data access onto one shared single-outstanding req/ack memory bus.
- Returns read data to the core through holding buffers.
- Drives the core's global `stall` input so the pipeline freezes until both accesses for the current cycle have completed.

Parameters:
- ADDR_WIDTH, 32, width of core and bus addresses.
- DATA_WIDTH, 32, width of data buses.
- SEL_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 255, bus wait limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rom_en  in  1  core instruction fetch request.
- rom_write_en  in  SEL_WIDTH  ignored; the instruction port is read-only.
- rom_addr  in  ADDR_WIDTH  fetch address.
- rom_write_data  in  DATA_WIDTH  ignored.
- rom_read_data  out  DATA_WIDTH  fetched instruction.
- ram_en  in  1  core data access request.
- ram_write_en  in  SEL_WIDTH  byte write enables; nonzero means store, zero means load.
- ram_addr  in  ADDR_WIDTH  data address.
- ram_write_data  in  DATA_WIDTH  store data.
- ram_read_data  out  DATA_WIDTH  load data.
- stall  out  1  freeze the core pipeline.
- bus_req  out  1  bus request, held until ack.
- bus_write_en  out  SEL_WIDTH  bus byte write enables.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_write_data  out  DATA_WIDTH  bus write data.
- bus_ack  in  1  transaction complete; read data valid this cycle.
- bus_read_data  in  DATA_WIDTH  bus read data.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Clock/reset: single clock clk; rst asynchronous, active-high. Reset clears:
  - state to IDLE, bus_req 0, bus_write_en 0, bus_addr 0, bus_write_data 0;
  - rom_read_data 0, ram_read_data 0, bus_error 0, timeout counter 0;
  - stall 1 (stall is combinational: stall = (state != READY)).
- FSM states: IDLE, DATA_REQ, INST_REQ, READY. All outputs registered except stall.
- IDLE:
  - ram_en=1: go to DATA_REQ. Register bus_addr=ram_addr, bus_write_en=ram_write_en, bus_write_data=ram_write_data, bus_req=1.
  - else rom_en=1: go to INST_REQ. Register bus_addr=rom_addr, bus_write_en=0, bus_req=1.
  - else: go to READY.
- DATA_REQ, on bus_ack:
  - If the access was a load, capture ram_read_data <= bus_read_data.
  - If rom_en: go to INST_REQ and issue the fetch on the next cycle with bus_req kept 1 and new address.
  - Else: bus_req <= 0, go to READY.
- INST_REQ, on bus_ack: rom_read_data <= bus_read_data, bus_req <= 0, go to READY.
- No ack: bus_req, bus_addr, bus_write_en and bus_write_data are held stable.
- READY: stall=0 for exactly one cycle; the core advances on that edge; next state IDLE.
- Ordering: the data access always precedes the fetch in the same core cycle.
- Buffer holding:
  - rom_read_data and ram_read_data hold their last captured value at all other times.
  - Stores do not modify ram_read_data.
- Minimum latency (bus_ack the cycle after bus_req rises):
  - fetch only: IDLE -> INST_REQ(1) -> READY, i.e. 2 stalled cycles;
  - fetch plus data: 3 stalled cycles;
  - no request: 1 stalled cycle.
- Core contract: the core holds rom_*/ram_* stable while stall=1. The bridge samples them only in IDLE (addresses) and DATA_REQ (rom_en, rom_addr).
- bus_ack outside DATA_REQ/INST_REQ is ignored.
- Reset mid-transaction: bus_req drops asynchronously; the abandoned bus transaction is the bus owner's concern.

Optional Feature:
- Macro: CORE_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs while in DATA_REQ or INST_REQ and clears on ack or state change.
  - When it reaches TIMEOUT_CYCLES without ack, the transaction completes as if acked with read data 0.
  - bus_req drops, and bus_error is set. bus_error stays set until reset.
- Undefined: no counter is present, bus_error is tied 0, and the FSM waits for ack indefinitely.

Decomposition:
- Shared package/include: state encoding constants (IDLE=2'd0, DATA_REQ=2'd1, INST_REQ=2'd2, READY=2'd3) plus existing ADDR_BUS/DATA_BUS/MEM_SEL_BUS widths.
- Optional sub-module: mem_bridge_timeout (counter plus sticky error), instantiated only under the macro.
- FSM and buffers stay in the top.

Test Plan:
- Fetch only: rom_en=1, rom_addr=0x00000100, ram_en=0, bus_ack one cycle after req with data 0x24020005.
  - Expect bus_addr=0x100, bus_write_en=0.
  - Expect stall high 2 cycles, then low 1 cycle with rom_read_data=0x24020005.
- Load plus fetch: ram_en=1, ram_write_en=0, ram_addr=0x80, rom_addr=0x104; acks return 0xDEADBEEF then 0x00000000.
  - Expect the data transaction precedes the fetch.
  - Expect ram_read_data=0xDEADBEEF, stall high 3 cycles.
- Store: ram_write_en=4'b0011, ram_write_data=0x1234ABCD.
  - Expect bus_write_en=0011 and bus_write_data=0x1234ABCD.
  - Expect ram_read_data unchanged from its prior value.
- Slow bus: ack delayed 7 cycles.
  - Expect bus_req, bus_addr and bus_write_en stable throughout, and stall held high.
- Reset mid DATA_REQ: assert rst asynchronously.
  - Expect bus_req=0, stall=1, and buffers 0 immediately; after release, a new fetch completes normally.
- With CORE_MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4: never ack.
  - Expect completion after 4 cycles, rom_read_data=0, and bus_error=1 persisting across further good transactions.
